// File: rtl/boot_ram.sv
`default_nettype none
// ==========================================================================
// boot_ram : 256x8 CPU RAM that zero-fills itself after reset, then loads a
//            program image from a valid/ready byte stream before releasing the CPU.
// Rev 1.0
// ==========================================================================
module boot_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_clk,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic              c_ri,
  input  logic              c_ro,
  inout  wire  [DATA_W-1:0] bus,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_reset,
  output logic              err
);

  localparam int                DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                ld_ready_q, ld_ready_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                ld_fire;
  logic                ld_end;

  assign ld_fire = (state_q == LOAD) && ld_valid && ld_ready_q;
  // The byte at the top address ends the load even without ld_last (overflow).
  assign ld_end  = ld_last || (ptr_q == PTR_MAX);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cpu_reset_d = cpu_reset_q;
    ld_ready_d  = ld_ready_q;
    mem_we      = 1'b0;
    mem_waddr   = ptr_q;
    mem_wdata   = '0;

    unique case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == PTR_MAX) begin
          state_d    = LOAD;
          ld_ready_d = 1'b1;
        end
      end
      LOAD: begin
        if (ld_fire) begin
          mem_we    = 1'b1;
          mem_wdata = ld_data;
          ptr_d     = ptr_q + 1'b1;
          if (ld_end) begin
            state_d     = RUN;
            ld_ready_d  = 1'b0;
            cpu_reset_d = 1'b0;
            err_d       = err_q | ~ld_last;
          end
        end
      end
      RUN: begin
        if (mem_clk) begin
          if (c_ri && c_ro) begin
            err_d = 1'b1;
          end else if (c_ri) begin
            mem_we    = 1'b1;
            mem_waddr = addr_bus;
            mem_wdata = bus;
          end else if (c_ro) begin
            rdata_d = mem[addr_bus];
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      ptr_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      ld_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cpu_reset_q <= cpu_reset_d;
      ld_ready_q  <= ld_ready_d;
    end
  end

  // Storage has no reset; the CLEAR pass is what zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus       = (state_q == RUN && c_ro && !c_ri) ? rdata_q : {DATA_W{1'bz}};
  assign ld_ready  = ld_ready_q;
  assign cpu_reset = cpu_reset_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_ram.sv
`default_nettype none
// ==========================================================================
// tb_boot_ram : directed + randomized bench for boot_ram against a memory model.
// Rev 1.0
// ==========================================================================
module tb_boot_ram;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_clk = 1'b0;
  logic [7:0] addr_bus = '0;
  logic       c_ri = 1'b0;
  logic       c_ro = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_last = 1'b0;
  logic [7:0] tb_drv = '0;
  logic       tb_drv_en = 1'b0;
  wire  [7:0] bus;
  wire        ld_ready;
  wire        cpu_reset;
  wire        err;

  assign bus = tb_drv_en ? tb_drv : 8'hzz;

  int         errors = 0;
  int         checks = 0;
  int         phase = 0;
  logic [7:0] model_mem [256];
  logic       model_err = 1'b0;

  always #5 clk = ~clk;

  boot_ram #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_clk   (mem_clk),
    .addr_bus  (addr_bus),
    .c_ri      (c_ri),
    .c_ro      (c_ro),
    .bus       (bus),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_reset (cpu_reset),
    .err       (err)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and set mem_clk for the coming rising edge.
  task automatic cyc();
    @(negedge clk);
    phase   = (phase + 1) % 3;
    mem_clk = (phase == 0);
  endtask

  task automatic wait_strobe();
    bit s;
    for (int n = 0; n < 6; n++) begin
      s = mem_clk;
      cyc();
      if (s) break;
    end
  endtask

  task automatic do_reset(input logic pv, input logic [7:0] pd, input logic pl);
    reset = 1'b1; c_ri = 1'b0; c_ro = 1'b0; tb_drv_en = 1'b0;
    ld_valid = pv; ld_data = pd; ld_last = pl;
    cyc();
    check("rst_cpu_reset", cpu_reset, 8'd1);
    check("rst_ld_ready", ld_ready, 8'd0);
    check("rst_err", err, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 255; i++) cyc();
    check("clear_ld_ready_still_low", ld_ready, 8'd0);
    cyc();
    check("clear_ld_ready_high", ld_ready, 8'd1);
    check("clear_cpu_reset_high", cpu_reset, 8'd1);
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    model_err = 1'b0;
  endtask

  task automatic load(input byte_q_t img, input bit has_last, input bit toggle);
    int  idx = 0;
    bit  on = 1'b1;
    bit  done = 1'b0;
    bit  acc;
    bit  term;
    for (int n = 0; n < 2000 && !done; n++) begin
      if (toggle && !on) begin
        ld_valid = 1'b0;
        ld_data  = 8'($urandom);
        ld_last  = 1'($urandom);
      end else begin
        ld_valid = 1'b1;
        ld_data  = img[idx];
        ld_last  = has_last && (idx == img.size() - 1);
      end
      acc  = ld_valid && ld_ready;
      term = acc && (ld_last || idx == 255);
      if (term) check("load_cpu_reset_before_last", cpu_reset, 8'd1);
      cyc();
      on = ~on;
      if (acc) begin
        model_mem[idx] = img[idx];
        idx++;
      end
      if (term) begin
        done = 1'b1;
        if (!(has_last && idx == img.size())) model_err = 1'b1;
      end
    end
    check("load_done", 8'(done), 8'd1);
    check("load_cpu_reset_fell", cpu_reset, 8'd0);
    check("load_ld_ready_fell", ld_ready, 8'd0);
    check("load_err", err, 8'(model_err));
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, input string tag);
    addr_bus = a; c_ri = 1'b0; c_ro = 1'b1; tb_drv_en = 1'b0;
    wait_strobe();
    check(tag, bus, model_mem[a]);
    c_ro = 1'b0; tb_drv = 8'h00; tb_drv_en = 1'b1;
    #1;
    check("bus_hiz_after_read", bus, 8'h00);
    tb_drv_en = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    addr_bus = a; c_ri = 1'b1; c_ro = 1'b0; tb_drv = d; tb_drv_en = 1'b1;
    wait_strobe();
    c_ri = 1'b0; tb_drv_en = 1'b0;
    model_mem[a] = d;
  endtask

  initial begin
    byte_q_t img;
    logic [7:0] a;
    logic [7:0] d;

    // Three-byte image with ld_valid already high during CLEAR.
    do_reset(1'b1, 8'h1A, 1'b0);
    img = {};
    img.push_back(8'h1A); img.push_back(8'h2B); img.push_back(8'h3C);
    load(img, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cpu_read(8'(i), "img3_read");

    // Write/read at 0x80, then a conflicting strobe at 0x10.
    cpu_write(8'h80, 8'h55);
    cpu_read(8'h80, "rd_0x80");
    check("err_before_conflict", err, 8'd0);
    addr_bus = 8'h10; c_ri = 1'b1; c_ro = 1'b1; tb_drv = 8'hAA; tb_drv_en = 1'b1;
    #1;
    check("conflict_bus_not_driven", bus, 8'hAA);
    wait_strobe();
    check("conflict_bus_not_driven_post", bus, 8'hAA);
    c_ri = 1'b0; c_ro = 1'b0; tb_drv_en = 1'b0;
    model_err = 1'b1;
    check("conflict_err", err, 8'(model_err));
    cpu_read(8'h10, "conflict_mem_unchanged");

    // Random CPU traffic over a small address window so reads hit writes.
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 1) == 1) cpu_write(a, d);
      else cpu_read(a, "rand_read");
    end
    check("err_sticky", err, 8'(model_err));

    // Random image delivered with ld_valid toggling every cycle.
    do_reset(1'b0, 8'h00, 1'b0);
    img = {};
    for (int i = 0; i < 20; i++) img.push_back(8'($urandom_range(1, 255)));
    load(img, 1'b1, 1'b1);
    for (int i = 0; i < 21; i++) cpu_read(8'(i), "toggle_img_read");

    // Overflow: 257 bytes with no ld_last.
    do_reset(1'b0, 8'h00, 1'b0);
    img = {};
    for (int i = 0; i < 257; i++) img.push_back(8'($urandom_range(1, 255)));
    load(img, 1'b0, 1'b0);
    ld_valid = 1'b1; ld_data = img[256];
    cyc();
    ld_valid = 1'b0;
    check("ovf_ld_ready_low", ld_ready, 8'd0);
    cpu_read(8'hFF, "ovf_mem255");
    cpu_read(8'h00, "ovf_mem0");

    // Reset in the middle of RUN re-zeroes memory.
    do_reset(1'b0, 8'h00, 1'b0);
    img = {};
    img.push_back(8'($urandom_range(1, 255)));
    load(img, 1'b1, 1'b0);
    cpu_write(8'h05, 8'h77);
    cpu_read(8'h05, "pre_reset_rd5");
    do_reset(1'b0, 8'h00, 1'b0);
    img = {};
    img.push_back(8'h99);
    load(img, 1'b1, 1'b0);
    cpu_read(8'h00, "reload_rd0");
    cpu_read(8'h05, "reload_rd5_zero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
